// File: rtl/snake_body_tracker_if.sv
// Handshake/bus bundle between the snake body tracker and the game/draw side.
// master: tick source and draw manager. slave: the tracker.
interface snake_body_tracker_if #(
  parameter int COORD_W = 6,
  parameter int LEN_W   = 8
);
  logic               step;
  logic [1:0]         dir;
  logic               grow;
  logic               tail_ack;
  logic [COORD_W-1:0] head_x, head_y;
  logic               head_valid;
  logic [COORD_W-1:0] tail_x, tail_y;
  logic               tail_valid;
  logic [LEN_W-1:0]   length;
  logic               busy;
  logic               game_over;
  logic               step_overrun;

  modport master (
    output step, dir, grow, tail_ack,
    input  head_x, head_y, head_valid, tail_x, tail_y, tail_valid,
           length, busy, game_over, step_overrun
  );

  modport slave (
    input  step, dir, grow, tail_ack,
    output head_x, head_y, head_valid, tail_x, tail_y, tail_valid,
           length, busy, game_over, step_overrun
  );
endinterface

// File: rtl/snake_body_tracker.sv
// Snake body engine: circular coordinate buffer plus occupancy map, one move per tick.
// Define SNAKE_WRAP_EN to make wall exits wrap around instead of ending the game.
module snake_body_tracker #(
  parameter int GRID_W  = 15,
  parameter int GRID_H  = 15,
  parameter int MAX_LEN = 225,
  parameter int COORD_W = 6,
  parameter int LEN_W   = 8
) (
  input  logic                 clk50,
  input  logic                 reset,
  snake_body_tracker_if.slave  bus
);
  localparam int CELLS = GRID_W * GRID_H;
  localparam int OCC_W = (CELLS > 1) ? $clog2(CELLS) : 1;
  localparam logic [COORD_W:0]   XMAX = (COORD_W+1)'(GRID_W - 1);
  localparam logic [COORD_W:0]   YMAX = (COORD_W+1)'(GRID_H - 1);
  localparam logic [COORD_W:0]   ONE  = (COORD_W+1)'(1);
  localparam logic [COORD_W-1:0] HX0  = COORD_W'(GRID_W / 2);
  localparam logic [COORD_W-1:0] HY0  = COORD_W'(GRID_H / 2);

  typedef enum logic [2:0] {IDLE, CALC, COMMIT, TAIL, DEAD} state_t;

  state_t             state;
  logic [1:0]         cur_dir;
  logic               grow_l;
  logic [COORD_W-1:0] hx, hy, nx_r, ny_r, tx, ty;
  logic [LEN_W-1:0]   len, wr_ptr, rd_ptr;
  logic [COORD_W-1:0] buf_x [MAX_LEN];
  logic [COORD_W-1:0] buf_y [MAX_LEN];
  logic [CELLS-1:0]   occ;
  logic               hv, tv, bsy, go, ovr;

  function automatic logic [OCC_W-1:0] cell_idx(input logic [COORD_W-1:0] x,
                                                input logic [COORD_W-1:0] y);
    return OCC_W'(y) * OCC_W'(GRID_W) + OCC_W'(x);
  endfunction

  function automatic logic [LEN_W-1:0] ptr_inc(input logic [LEN_W-1:0] p);
    return (p == LEN_W'(MAX_LEN - 1)) ? '0 : p + LEN_W'(1);
  endfunction

  // Next head cell, evaluated from registered head/direction during CALC.
  logic [COORD_W:0]   ex, ey;
  logic [COORD_W-1:0] nx, ny;
  logic               oob, wall, tail_hit, hit, eff_grow;

  always_comb begin
    ex = {1'b0, hx};
    ey = {1'b0, hy};
    case (cur_dir)
      2'b00:   ey = ey - ONE;
      2'b01:   ex = ex + ONE;
      2'b10:   ey = ey + ONE;
      default: ex = ex - ONE;
    endcase
    oob = (ex > XMAX) || (ey > YMAX);
`ifdef SNAKE_WRAP_EN
    nx   = (ex > XMAX) ? ((cur_dir == 2'b01) ? '0 : XMAX[COORD_W-1:0]) : ex[COORD_W-1:0];
    ny   = (ey > YMAX) ? ((cur_dir == 2'b10) ? '0 : YMAX[COORD_W-1:0]) : ey[COORD_W-1:0];
    wall = 1'b0;
`else
    nx   = ex[COORD_W-1:0];
    ny   = ey[COORD_W-1:0];
    wall = oob;
`endif
    eff_grow = grow_l && (len < LEN_W'(MAX_LEN));
    tail_hit = (nx == buf_x[rd_ptr]) && (ny == buf_y[rd_ptr]);
    // Moving into the retiring tail cell is legal unless the tail stays put.
    hit      = !wall && occ[cell_idx(nx, ny)] && !(tail_hit && !eff_grow);
  end

  always_ff @(posedge clk50) begin
    if (reset) begin
      state    <= IDLE;
      cur_dir  <= 2'b01;
      grow_l   <= 1'b0;
      hx       <= HX0;
      hy       <= HY0;
      nx_r     <= '0;
      ny_r     <= '0;
      tx       <= '0;
      ty       <= '0;
      len      <= LEN_W'(1);
      wr_ptr   <= ptr_inc('0);
      rd_ptr   <= '0;
      buf_x[0] <= HX0;
      buf_y[0] <= HY0;
      occ      <= '0;
      occ[cell_idx(HX0, HY0)] <= 1'b1;
      hv       <= 1'b0;
      tv       <= 1'b0;
      bsy      <= 1'b0;
      go       <= 1'b0;
      ovr      <= 1'b0;
    end else begin
      hv <= 1'b0;
      if (bus.step && (state == CALC || state == COMMIT || state == TAIL))
        ovr <= 1'b1;
      case (state)
        IDLE: if (bus.step) begin
          grow_l <= bus.grow;
          if ((bus.dir ^ cur_dir) != 2'b10) cur_dir <= bus.dir;
          bsy    <= 1'b1;
          state  <= CALC;
        end
        CALC: begin
          if (wall || hit) begin
            go    <= 1'b1;
            bsy   <= 1'b0;
            state <= DEAD;
          end else begin
            nx_r  <= nx;
            ny_r  <= ny;
            state <= COMMIT;
          end
        end
        COMMIT: begin
          buf_x[wr_ptr] <= nx_r;
          buf_y[wr_ptr] <= ny_r;
          wr_ptr        <= ptr_inc(wr_ptr);
          hx            <= nx_r;
          hy            <= ny_r;
          hv            <= 1'b1;
          if (eff_grow) begin
            len   <= len + LEN_W'(1);
            bsy   <= 1'b0;
            state <= IDLE;
          end else begin
            tx     <= buf_x[rd_ptr];
            ty     <= buf_y[rd_ptr];
            rd_ptr <= ptr_inc(rd_ptr);
            occ[cell_idx(buf_x[rd_ptr], buf_y[rd_ptr])] <= 1'b0;
            tv     <= 1'b1;
            state  <= TAIL;
          end
          // Placed after the clear so the head bit wins when both hit one cell.
          occ[cell_idx(nx_r, ny_r)] <= 1'b1;
        end
        TAIL: if (bus.tail_ack) begin
          tv    <= 1'b0;
          bsy   <= 1'b0;
          state <= IDLE;
        end
        DEAD: ;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.head_x       = hx;
  assign bus.head_y       = hy;
  assign bus.head_valid   = hv;
  assign bus.tail_x       = tx;
  assign bus.tail_y       = ty;
  assign bus.tail_valid   = tv;
  assign bus.length       = len;
  assign bus.busy         = bsy;
  assign bus.game_over    = go;
  assign bus.step_overrun = ovr;
endmodule

// File: tb/tb_snake_body_tracker.sv
// Scoreboard bench for snake_body_tracker: a queue-of-cells body model predicts
// each committed head and erased tail; the DUT's pulses pop and compare them.
module tb_snake_body_tracker;
  localparam int W = 15, H = 15, MAXL = 225;

  logic clk50 = 1'b0;
  logic reset = 1'b1;
  always #5 clk50 = ~clk50;

  snake_body_tracker_if #(.COORD_W(6), .LEN_W(8)) sif ();
  snake_body_tracker dut (.clk50(clk50), .reset(reset), .bus(sif));

  typedef struct { int x; int y; } cell_t;
  typedef struct { int x; int y; int len; } hexp_t;

  cell_t body [$];
  hexp_t hq [$];
  cell_t tq [$];
  int    mdir;
  bit    mdead;
  int    n_chk = 0, n_err = 0;

  task automatic chk(input string tag, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s got=%0d want=%0d", tag, act, exp);
    end
  endtask

  task automatic model_reset();
    body.delete(); hq.delete(); tq.delete();
    body.push_back('{W/2, H/2});
    mdir  = 1;
    mdead = 1'b0;
  endtask

  task automatic model_step(input int d, input int g, output bit coll);
    cell_t n;
    bit eg;
    if ((d ^ mdir) != 2) mdir = d;
    n = body[body.size()-1];
    case (mdir)
      0: n.y--;
      1: n.x++;
      2: n.y++;
      default: n.x--;
    endcase
    eg   = (g != 0) && (body.size() < MAXL);
    coll = 1'b0;
`ifdef SNAKE_WRAP_EN
    n.x = (n.x + W) % W;
    n.y = (n.y + H) % H;
`else
    if (n.x < 0 || n.x >= W || n.y < 0 || n.y >= H) coll = 1'b1;
`endif
    for (int i = 0; i < body.size(); i++)
      if (body[i].x == n.x && body[i].y == n.y && !(i == 0 && !eg)) coll = 1'b1;
    if (coll) begin
      mdead = 1'b1;
      return;
    end
    body.push_back(n);
    if (!eg) tq.push_back(body.pop_front());
    hq.push_back('{n.x, n.y, body.size()});
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) begin @(posedge clk50); #1; end
    reset = 1'b0;
    model_reset();
  endtask

  // One tick; ov keeps step high into CALC to provoke an overrun.
  task automatic do_step(input int d, input int g, input bit ov);
    bit coll, got, was_dead, exp_tail;
    int k, tq_n;
    hexp_t he;
    cell_t te, hd;
    coll = 1'b0;
    was_dead = mdead;
    tq_n = tq.size();
    if (!was_dead) model_step(d, g, coll);
    exp_tail = tq.size() > tq_n;
    sif.step = 1'b1; sif.dir = 2'(d); sif.grow = (g != 0);
    @(posedge clk50); #1;
    if (!ov) sif.step = 1'b0;
    if (was_dead) begin
      got = 1'b0;
      repeat (4) begin
        @(posedge clk50); #1;
        sif.step = 1'b0;
        if (sif.head_valid) got = 1'b1;
      end
      hd = body[body.size()-1];
      chk("dead_hv", int'(got), 0);
      chk("dead_go", int'(sif.game_over), 1);
      chk("dead_busy", int'(sif.busy), 0);
      chk("dead_hx", int'(sif.head_x), hd.x);
      chk("dead_ovr", int'(sif.step_overrun), 0);
      return;
    end
    k = 1; got = 1'b0;
    while (!got && k < 8) begin
      @(posedge clk50); #1;
      k++;
      sif.step = 1'b0;
      if (k == 2 && !coll) chk("busy_mid", int'(sif.busy), 1);
      if (sif.head_valid || sif.game_over) got = 1'b1;
    end
    if (coll) begin
      chk("coll_lat", got ? k : 99, 2);
      chk("coll_go", int'(sif.game_over), 1);
      chk("coll_hv", int'(sif.head_valid), 0);
      chk("coll_busy", int'(sif.busy), 0);
      return;
    end
    chk("hv_lat", got ? k : 99, 3);
    if (!got) return;
    he = hq.pop_front();
    chk("head_x", int'(sif.head_x), he.x);
    chk("head_y", int'(sif.head_y), he.y);
    chk("length", int'(sif.length), he.len);
    chk("go_clr", int'(sif.game_over), 0);
    if (exp_tail) begin
      te = tq.pop_front();
      chk("tv_up", int'(sif.tail_valid), 1);
      chk("tail_x", int'(sif.tail_x), te.x);
      chk("tail_y", int'(sif.tail_y), te.y);
      sif.tail_ack = 1'b1;
      @(posedge clk50); #1;
      sif.tail_ack = 1'b0;
      chk("tv_drop", int'(sif.tail_valid), 0);
    end else begin
      chk("tv_none", int'(sif.tail_valid), 0);
    end
    chk("idle_busy", int'(sif.busy), 0);
    if (ov) chk("ovr", int'(sif.step_overrun), 1);
  endtask

  initial begin
    sif.step = 1'b0; sif.dir = 2'b01; sif.grow = 1'b0; sif.tail_ack = 1'b0;
    do_reset();
    chk("rst_hx", int'(sif.head_x), 7);
    chk("rst_hy", int'(sif.head_y), 7);
    chk("rst_len", int'(sif.length), 1);
    chk("rst_busy", int'(sif.busy), 0);
    chk("rst_go", int'(sif.game_over), 0);
    chk("rst_tv", int'(sif.tail_valid), 0);
    chk("rst_hv", int'(sif.head_valid), 0);
    chk("rst_ovr", int'(sif.step_overrun), 0);
    chk("rst_tx", int'(sif.tail_x), 0);

    // Plain move right
    do_step(1, 0, 1'b0);

    // Three grows upward from reset
    do_reset();
    repeat (3) do_step(0, 1, 1'b0);

    // Reverse request ignored; extra step during CALC flagged as overrun
    do_reset();
    do_step(3, 0, 1'b1);
    do_step(0, 0, 1'b0);
    chk("ovr_sticky", int'(sif.step_overrun), 1);

    // Reset in the middle of the tail handshake
    do_reset();
    sif.step = 1'b1; sif.dir = 2'b01; sif.grow = 1'b0;
    @(posedge clk50); #1; sif.step = 1'b0;
    repeat (2) begin @(posedge clk50); #1; end
    chk("mid_tv", int'(sif.tail_valid), 1);
    reset = 1'b1;
    @(posedge clk50); #1;
    reset = 1'b0;
    model_reset();
    chk("mid_tv_drop", int'(sif.tail_valid), 0);
    chk("mid_hx", int'(sif.head_x), 7);
    chk("mid_busy", int'(sif.busy), 0);
    do_step(1, 0, 1'b0);

    // 2x2 loop chasing its own tail, long enough to wrap both pointers
    do_reset();
    do_step(0, 1, 1'b0);
    do_step(1, 1, 1'b0);
    do_step(2, 1, 1'b0);
    for (int i = 0; i < 60; i++) begin
      do_step(3, 0, 1'b0);
      do_step(0, 0, 1'b0);
      do_step(1, 0, 1'b0);
      do_step(2, 0, 1'b0);
    end
    chk("loop_go", int'(sif.game_over), 0);
    // Same move with grow keeps the tail in place: self collision
    do_step(3, 1, 1'b0);
    chk("loop_grow_go", int'(sif.game_over), 1);

    // Right wall
    do_reset();
    repeat (7) do_step(1, 0, 1'b0);
    do_step(1, 0, 1'b0);
`ifndef SNAKE_WRAP_EN
    chk("wall_go", int'(sif.game_over), 1);
`endif
    do_step(1, 0, 1'b0);
    do_step(0, 1, 1'b0);

    chk("sb_head_empty", hq.size(), 0);
    chk("sb_tail_empty", tq.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/snake_body_tracker.md
# snake_body_tracker

Parametrised snake-body engine that replaces the fixed 15x15 occupancy-bitmap scheme with a circular coordinate buffer plus an occupancy map. It sits between the game-clock mux and the draw manager. On each game tick it:
- advances the head;
- detects wall and self collisions;
- grows or retires the tail;
- hands the new head and the erased tail cell to the drawing side through a valid/ack handshake.

## Interface
Parameters:
- GRID_W, 15, playfield width in cells (2..64)
- GRID_H, 15, playfield height in cells (2..64)
- MAX_LEN, 225, body buffer depth; must be <= GRID_W*GRID_H
- COORD_W, 6, coordinate width; must hold GRID_W-1 and GRID_H-1
- LEN_W, 8, length width; must hold MAX_LEN

Ports:
- clk50  in  1  system clock; one clock domain, all logic on rising edge
- reset  in  1  synchronous, active-high reset
- step  in  1  one-cycle tick request (edge-detected game clock)
- dir  in  2  requested direction: 00 up, 01 right, 10 down, 11 left
- grow  in  1  item eaten; sampled together with step
- head_x, head_y  out  COORD_W  current head cell
- head_valid  out  1  one-cycle pulse: new head committed
- tail_x, tail_y  out  COORD_W  cell to erase
- tail_valid  out  1  erase request, held until accepted
- tail_ack  in  1  draw side accepted tail cell
- length  out  LEN_W  current body length
- busy  out  1  high in any state other than IDLE or DEAD
- game_over  out  1  sticky collision flag
- step_overrun  out  1  sticky: a step arrived while busy

## Operation
- The FSM has five states: IDLE, CALC, COMMIT, TAIL, DEAD.
- Reset values:
  - state IDLE;
  - head = (GRID_W/2, GRID_H/2);
  - length = 1, with that cell stored in the buffer and its occupancy bit set;
  - current direction = 01;
  - tail_x/tail_y = 0;
  - all flags and pulses = 0.
- IDLE, step=1:
  - latch grow;
  - accept dir unless it is the exact reverse of the current direction (reverse is ignored, previous direction kept);
  - go to CALC.
- IDLE, step=0: stay.
- Effective grow = latched grow AND length < MAX_LEN. Grow at MAX_LEN acts as a plain move.
- CALC computes the next head cell. Collision when:
  - the next cell is outside [0,GRID_W-1]x[0,GRID_H-1]; or
  - occupancy[next] is set, except when next equals the current tail AND effective grow is 0 (chasing the tail is legal).
  - On collision: game_over=1, go to DEAD; head is not updated.
  - Otherwise go to COMMIT.
- COMMIT:
  - write next cell at the write pointer, advance it (modulo MAX_LEN);
  - update head_x/head_y and pulse head_valid.
  - If effective grow: length+1, go to IDLE.
  - Else: load tail_x/tail_y from the read pointer, advance it, clear that occupancy bit, assert tail_valid, go to TAIL.
  - When tail cell equals the new head, the set of the head bit takes precedence over the clear.
- TAIL: hold tail_valid and tail_x/tail_y stable until tail_ack=1. On that cycle drop tail_valid and go to IDLE.
- DEAD: ignore step, grow and tail_ack; hold all outputs. Only reset exits.
- step while busy: ignored and step_overrun set (sticky until reset). step in DEAD is ignored without setting the flag.
- Pointer wrap-around: the write and read pointers wrap modulo MAX_LEN independently. length always equals the number of stored entries.

## Timing
- step sampled in cycle 0, then CALC in cycle 1 and COMMIT in cycle 2.
- head_valid, head_x/head_y and length updates are visible in cycle 3. tail_valid also rises in cycle 3.
- Collision: game_over visible in cycle 2.
- Minimum step spacing is 3 cycles with grow. Without grow it is 3 cycles + the tail handshake; tail_ack may be high in cycle 3 at earliest, with IDLE reached in cycle 4.
- reset asserted in any state returns every register to its reset value on the next edge, including mid-handshake. tail_valid drops without ack.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration
- SNAKE_WRAP_EN defined: wall exits wrap modulo GRID_W/GRID_H; only self collision sets game_over.
- Without SNAKE_WRAP_EN: a wall exit is a collision, as described in Operation.

## Test plan
- Reset with defaults -> head=(7,7), length=1, busy=0, game_over=0, tail_valid=0.
- step with dir=01, grow=0, tail_ack returned in cycle 3 -> head=(8,7) and head_valid pulse in cycle 3; tail=(7,7), tail_valid cleared after ack; length=1.
- Three steps with grow=1, dir=00 -> head=(7,4), length=4, tail_valid never asserted.
- From head=(14,7) step with dir=01 -> without macro, game_over=1 in cycle 2 and state stays DEAD through further steps; with SNAKE_WRAP_EN, head=(0,7).
- Current direction 01, step with dir=11 -> head moves right; step during CALC -> ignored, step_overrun=1.
- Length-4 snake steering a 2x2 loop onto its own tail without grow -> legal, game_over=0. Same loop with grow=1 -> game_over=1.
